// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dram_pkg
//  Description : Shared types and constants for the multi-lane DRAM model.
//                - state_t  : request FSM encoding (IDLE / WAIT / RESP)
//                - OP_READ / OP_WRITE : values of the request rdwr bit
//                - CNT_W    : width of the latency counter
//  Revision    : 1.0  initial release
// ============================================================================
package dram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    localparam int CNT_W = 8;

endpackage : dram_pkg
`default_nettype wire

// File: rtl/dram_store.sv
`default_nettype none
// ============================================================================
//  Module      : dram_store
//  Description : DEPTH x DATA_W storage array with NUM_LANES combinational
//                read ports and NUM_LANES write ports. All write ports commit
//                together on a single strobe; where several enabled ports hit
//                the same word, the highest-index port wins.
//  Ports       : clk    - clock
//                commit - write strobe for all ports this cycle
//                we     - per-port write enable (qualified by commit)
//                waddr  - per-port write index, IDX_W bits each
//                wdata  - per-port write data, DATA_W bits each
//                raddr  - per-port read index, IDX_W bits each
//                rdata  - per-port read data (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module dram_store #(
    parameter int NUM_LANES = 8,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 1024,
    parameter int IDX_W     = 10
) (
    input  logic                          clk,
    input  logic                          commit,
    input  logic [NUM_LANES-1:0]          we,
    input  logic [NUM_LANES*IDX_W-1:0]    waddr,
    input  logic [NUM_LANES*DATA_W-1:0]   wdata,
    input  logic [NUM_LANES*IDX_W-1:0]    raddr,
    output logic [NUM_LANES*DATA_W-1:0]   rdata
);

    // Contents are deliberately left without reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Ascending loop: a later non-blocking write to the same word overrides
    // an earlier one, which gives the higher lane priority on collisions.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (we[i]) begin
                    r_mem[waddr[i*IDX_W +: IDX_W]] <= wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_rd
        assign rdata[g*DATA_W +: DATA_W] = r_mem[raddr[g*IDX_W +: IDX_W]];
    end

endmodule : dram_store
`default_nettype wire

// File: rtl/dram_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : dram_lanes
//  Description : Parametrised multi-lane fixed-latency DRAM behavioural model.
//                A request carries up to NUM_LANES lane accesses; it is
//                performed LATENCY cycles after acceptance and answered with
//                a valid/ready response that holds under backpressure.
//  Ports       : clk, reset_n (synchronous, active-low)
//                req_valid/req_ready, req_rdwr (1=read), req_en, req_addr,
//                req_wdata      - request channel, lanes packed LSB first
//                resp_valid/resp_ready, resp_rdwr, resp_en, resp_rdata,
//                resp_err       - response channel, lanes packed LSB first
//  Revision    : 1.0  initial release
// ============================================================================
module dram_lanes
    import dram_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 64,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 20
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_rdwr,
    input  logic [NUM_LANES-1:0]          req_en,
    input  logic [NUM_LANES*ADDR_W-1:0]   req_addr,
    input  logic [NUM_LANES*DATA_W-1:0]   req_wdata,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_rdwr,
    output logic [NUM_LANES-1:0]          resp_en,
    output logic [NUM_LANES*DATA_W-1:0]   resp_rdata,
    output logic [NUM_LANES-1:0]          resp_err
);

    localparam int               IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_LAT_LAST = CNT_W'(LATENCY - 1);
    // One extra bit so DEPTH itself is representable even when ADDR_W is tight.
    localparam logic [ADDR_W:0]  c_DEPTH    = (ADDR_W + 1)'(DEPTH);

    if ((LATENCY < 1) || (LATENCY > 255)) begin : g_bad_latency
        $error("dram_lanes: LATENCY must be in 1..255");
    end

    if (IDX_W > ADDR_W) begin : g_bad_addr_w
        $error("dram_lanes: ADDR_W too narrow to address DEPTH words");
    end

    state_t                      r_state;
    state_t                      w_next_state;
    logic [CNT_W-1:0]            r_cnt;

    logic                        r_rdwr;
    logic [NUM_LANES-1:0]        r_en;
    logic [NUM_LANES*ADDR_W-1:0] r_addr;
    logic [NUM_LANES*DATA_W-1:0] r_wdata;

    logic                        w_accept;
    logic                        w_done;
    logic                        w_commit;
    logic [NUM_LANES-1:0]        w_err;
    logic [NUM_LANES-1:0]        w_hit;
    logic [NUM_LANES-1:0]        w_we;
    logic [NUM_LANES*IDX_W-1:0]  w_idx;
    logic [NUM_LANES*DATA_W-1:0] w_store_rdata;
    logic [NUM_LANES*DATA_W-1:0] w_lane_rdata;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_done   = (r_state == WAIT) && (r_cnt == c_LAT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (req_valid)               w_next_state = WAIT;
            WAIT:    if (r_cnt == c_LAT_LAST)     w_next_state = RESP;
            RESP:    if (resp_ready)              w_next_state = IDLE;
            default:                              w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        w_commit   = 1'b0;
        unique case (r_state)
            IDLE:    req_ready  = 1'b1;
            // Reset in the commit cycle must suppress the write.
            WAIT:    w_commit   = w_done && reset_n && (r_rdwr == OP_WRITE);
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Latency counter and request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_rdwr  <= OP_WRITE;
            r_en    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_rdwr  <= req_rdwr;
            r_en    <= req_en;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end else if (r_state == WAIT) begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane range check, store indexing and read-data masking
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign w_err[g] = r_en[g] && ({1'b0, r_addr[g*ADDR_W +: ADDR_W]} >= c_DEPTH);
        assign w_hit[g] = r_en[g] && !w_err[g];
        assign w_we[g]  = w_hit[g] && (r_rdwr == OP_WRITE);
        assign w_idx[g*IDX_W +: IDX_W] = r_addr[g*ADDR_W +: IDX_W];
        assign w_lane_rdata[g*DATA_W +: DATA_W] =
            (w_hit[g] && (r_rdwr == OP_READ)) ? w_store_rdata[g*DATA_W +: DATA_W]
                                              : {DATA_W{1'b0}};
    end

    dram_store #(
        .NUM_LANES (NUM_LANES),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_store (
        .clk    (clk),
        .commit (w_commit),
        .we     (w_we),
        .waddr  (w_idx),
        .wdata  (r_wdata),
        .raddr  (w_idx),
        .rdata  (w_store_rdata)
    );

    // ------------------------------------------------------------------
    // Response registers: loaded on the WAIT->RESP edge and held until the
    // next request completes, so they stay stable under backpressure.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_rdwr  <= 1'b0;
            resp_en    <= '0;
            resp_err   <= '0;
            resp_rdata <= '0;
        end else if (w_done) begin
            resp_rdwr  <= r_rdwr;
            resp_en    <= r_en;
            resp_err   <= w_err;
            resp_rdata <= w_lane_rdata;
        end
    end

endmodule : dram_lanes
`default_nettype wire
